segre_icache: RTL
=================

# segre_icache

Direct-mapped instruction cache with a blocking refill engine, sitting between the fetch stage PC and the instruction memory port. It produces the hit indication that the pipeline controller turns into the fetch stall (`ic_hit_o` low means block IF and inject a NOP into ID). While a refill is in progress the fetch stage holds its PC and keeps `req_i` asserted until the line is installed.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: byte address width.
- `WORD_WIDTH`, default 32: instruction width.
- `LINE_WORDS`, default 4: words per line; power of two, at least 2.
- `NUM_LINES`, default 16: number of lines; power of two.

Ports:
- `clk_i` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_i` input, 1 bit: reset, synchronous, active-high.
- `req_i` input, 1 bit: fetch request for `pc_i` this cycle.
- `pc_i` input, ADDR_WIDTH bits: fetch byte address; bits [1:0] are ignored.
- `flush_i` input, 1 bit: invalidate all lines.
- `ic_hit_o` output, 1 bit: `instr_o` is valid for `pc_i`, or no request is pending.
- `instr_o` output, WORD_WIDTH bits: instruction at `pc_i`.
- `mem_rd_o` output, 1 bit: line read request.
- `mem_addr_o` output, ADDR_WIDTH bits: line-aligned read address.
- `mem_gnt_i` input, 1 bit: memory accepts the request.
- `mem_rvalid_i` input, 1 bit: one data beat is present.
- `mem_rdata_i` input, WORD_WIDTH bits: beat data; beats arrive in ascending word order.

## Operation

Address split, with OFF = log2(LINE_WORDS) and IDX = log2(NUM_LINES):
- word offset = `pc_i[OFF+1:2]`
- index = `pc_i[OFF+IDX+1:OFF+2]`
- tag = remaining upper bits.

Storage:
- data array of NUM_LINES × LINE_WORDS words;
- tag array;
- per-line valid bits, cleared by reset and by `flush_i`.

Lookup is combinational. `hit = valid[idx] && tag[idx] == pc tag`, and `instr_o = data[idx][offset]`. `instr_o` is don't-care when there is no hit.

`ic_hit_o = !req_i || (state == IDLE && hit)`. It is forced to 0 in REQ and FILL whenever `req_i` = 1.

Refill state machine:
- **IDLE.** If `req_i` is high, `hit` is false and `flush_i` is low: latch the line-aligned `pc_i` into `miss_addr` and go to REQ. Otherwise stay in IDLE.
- **REQ.** Drive `mem_rd_o` = 1 and `mem_addr_o` = `miss_addr`. When `mem_gnt_i` = 1, go to FILL and clear the beat counter. The request stays asserted until it is granted.
- **FILL.** On each `mem_rvalid_i`, write `mem_rdata_i` to `data[miss_idx][beat_cnt]` and increment `beat_cnt`. On the beat where `beat_cnt == LINE_WORDS-1`:
  - write the tag;
  - set `valid[miss_idx]`, unless a flush is pending or `flush_i` is high that cycle;
  - go to IDLE.
- `mem_addr_o` equals `miss_addr` in every state and is 0 after reset. `mem_rd_o` is 1 only in REQ.

Boundary rules:
- `mem_rvalid_i` is ignored in IDLE and REQ. `mem_gnt_i` is ignored outside REQ.
- A change of `pc_i` during REQ or FILL does not redirect the refill. The latched line completes, and a lookup happens afresh in IDLE.
- Flush:
  - in IDLE or REQ, it clears all valid bits the next cycle;
  - in FILL, it clears all valid bits and sets a sticky `flush_pend`, so the line being filled is written but left invalid. `flush_pend` clears on the return to IDLE.
- Reset during REQ or FILL: the state goes to IDLE, valid bits and `flush_pend` clear, `mem_rd_o` drops, and beats still in flight are ignored. The memory side tolerates an abandoned transaction.
- A miss in the same cycle as `flush_i`: the miss is not taken that cycle and is re-evaluated on the next cycle.

Reset values: state IDLE, all valid bits 0, `beat_cnt` 0, `miss_addr` 0, `flush_pend` 0, `mem_rd_o` 0. `ic_hit_o` is then `!req_i`.

## Timing

- Hit: zero latency; `ic_hit_o` and `instr_o` are valid in the same cycle as `pc_i`.
- Miss detected in cycle T: `mem_rd_o` rises at T+1.
- Grant in cycle G: the first beat can be accepted at G+1.
- Last beat in cycle L: the state is IDLE and the line is valid at L+1, so `ic_hit_o` = 1 at L+1 for an unchanged `pc_i`.
- Minimum miss penalty, with the grant at T+1 and back-to-back beats: T+1+LINE_WORDS+1, which is 6 cycles for LINE_WORDS=4.
- Gaps between beats are allowed and hold `beat_cnt`.
- Data and tag writes take effect on the clock edge. The lookup in the same cycle as the final write still sees the old contents.

## Test plan

- **Cold miss then hit.** After reset, `req_i`=1, `pc_i`=0x0000_0104; memory grants at once and returns beats 0xA0..0xA3 back-to-back. Required:
  - `mem_rd_o` high for exactly 1 cycle with `mem_addr_o`=0x0000_0100;
  - `ic_hit_o`=0 for 6 cycles, then `ic_hit_o`=1 with `instr_o`=0xA1;
  - `pc_i`=0x10C then hits immediately with 0xA3.
- **Conflict eviction.** Fill 0x100, then request 0x1100 (same index, different tag): miss and refill. Re-requesting 0x100 then misses again.
- **Grant stall and beat gaps.** Hold `mem_gnt_i`=0 for 3 cycles, then insert one idle cycle between each beat. Required: `mem_rd_o` holds for 4 cycles, `mem_addr_o` stays stable, and every word lands at the correct offset.
- **Flush during FILL.** Assert `flush_i` after beat 1. Required: the refill completes and the state returns to IDLE, but the same `pc_i` misses again and triggers a new `mem_rd_o`.
- **Reset mid-fill.** Assert `rst_i` after beat 2, then deliver 2 more stray beats. Required: `mem_rd_o`=0, stray beats ignored, and the next request misses.
- **No request.** `req_i`=0 with an uncached `pc_i`. Required: `ic_hit_o`=1 and `mem_rd_o` stays 0.

Source files
------------

// File: rtl/segre_icache.sv
// Direct-mapped instruction cache with a blocking line-refill engine.
// Lookup is combinational; misses fetch a whole line in ascending word order.
module segre_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  flush_i,
    output logic                  ic_hit_o,
    output logic [WORD_WIDTH-1:0] instr_o,
    output logic                  mem_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i
);

    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - OFF - IDX - 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;

    localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

    logic [WORD_WIDTH-1:0] data_q [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];

    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [1:0]            state_q, state_d;
    logic [OFF-1:0]        beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic                  flush_pend_q, flush_pend_d;

    logic                  data_we;
    logic                  tag_we;
    logic                  set_valid;

    logic [OFF-1:0]        pc_off;
    logic [IDX-1:0]        pc_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic [IDX-1:0]        miss_idx;
    logic [TAG_W-1:0]      miss_tag;
    logic                  hit;
    logic                  unused_bits;

    assign pc_off   = pc_i[OFF+1:2];
    assign pc_idx   = pc_i[OFF+IDX+1:OFF+2];
    assign pc_tag   = pc_i[ADDR_WIDTH-1:OFF+IDX+2];
    assign miss_idx = miss_addr_q[OFF+IDX+1:OFF+2];
    assign miss_tag = miss_addr_q[ADDR_WIDTH-1:OFF+IDX+2];

    assign unused_bits = ^{pc_i[1:0], miss_addr_q[OFF+1:0]};

    assign hit        = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign instr_o    = data_q[pc_idx][pc_off];
    assign ic_hit_o   = !req_i || ((state_q == S_IDLE) && hit);
    assign mem_rd_o   = (state_q == S_REQ);
    assign mem_addr_o = miss_addr_q;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        miss_addr_d  = miss_addr_q;
        flush_pend_d = flush_pend_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        set_valid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_i && !hit && !flush_i) begin
                    miss_addr_d = {pc_i[ADDR_WIDTH-1:OFF+2], {(OFF+2){1'b0}}};
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    beat_cnt_d = '0;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    data_we    = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        // A flush seen at any point of the fill leaves the new line invalid.
                        tag_we       = 1'b1;
                        set_valid    = !flush_pend_q && !flush_i;
                        flush_pend_d = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (set_valid) begin
            valid_d[miss_idx] = 1'b1;
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            beat_cnt_q   <= '0;
            miss_addr_q  <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            beat_cnt_q   <= beat_cnt_d;
            miss_addr_q  <= miss_addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk_i) begin
        if (data_we && !rst_i) begin
            data_q[miss_idx][beat_cnt_q] <= mem_rdata_i;
        end
        if (tag_we && !rst_i) begin
            tag_q[miss_idx] <= miss_tag;
        end
    end

endmodule
